// File: rtl/br_amba_axi_isolate_rst_seq_if.sv
// Handshake bundle between the reset sequencer, its requester
// and the AXI isolate stage.
interface br_amba_axi_isolate_rst_seq_if;
   logic reset_req;
   logic reset_busy;
   logic reset_done;
   logic isolate_req;
   logic isolate_done;
   logic downstream_rst;
   logic timeout_err;
   logic timeout_clear;

   modport slave (
      input  reset_req,
      input  isolate_done,
      input  timeout_clear,
      output reset_busy,
      output reset_done,
      output isolate_req,
      output downstream_rst,
      output timeout_err
   );

   modport master (
      output reset_req,
      output isolate_done,
      output timeout_clear,
      input  reset_busy,
      input  reset_done,
      input  isolate_req,
      input  downstream_rst,
      input  timeout_err
   );
endinterface

// File: rtl/br_amba_axi_isolate_rst_seq.sv
// Isolate-then-reset sequencer for a downstream AXI subordinate,
// using a 4-phase handshake with the isolate stage.
module br_amba_axi_isolate_rst_seq #(
   parameter int ResetCycles   = 16,
   parameter int TimeoutCycles = 1024
) (
   input logic clk,
   input logic rst_n,
   br_amba_axi_isolate_rst_seq_if.slave bus
);
   localparam int CntMax = (ResetCycles > TimeoutCycles) ?
                           ResetCycles : TimeoutCycles;
   localparam int CW = (CntMax < 1) ? 1 : $clog2(CntMax + 1);
   localparam logic [CW-1:0] RLoad = CW'(ResetCycles - 1);
   localparam logic [CW-1:0] TMax  = CW'(TimeoutCycles);
   localparam logic [CW-1:0] One   = CW'(1);
   localparam bit TEn = (TimeoutCycles > 0);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_ISO  = 3'd1;
   localparam logic [2:0] S_RST  = 3'd2;
   localparam logic [2:0] S_REL  = 3'd3;
   localparam logic [2:0] S_DONE = 3'd4;

   if (ResetCycles < 1) begin : g_bad_rc
      $error("ResetCycles must be >= 1");
   end
   if (TimeoutCycles < 0) begin : g_bad_tc
      $error("TimeoutCycles must be >= 0");
   end

   logic [2:0]    r_state;
   logic [2:0]    w_nxt;
   logic [CW-1:0] r_cnt;
   logic [CW-1:0] w_cnt;
   logic          r_fired;
   logic          w_wait;
   logic          w_hit;
   logic          r_ireq;
   logic          r_drst;
   logic          r_busy;
   logic          r_done;
   logic          r_err;

   // One timeout event per wait phase, so a clear can stick
   assign w_wait = (r_state == S_ISO) || (r_state == S_REL);
   assign w_hit  = TEn && w_wait && (r_cnt == TMax) && !r_fired;

   always_comb begin
      w_nxt = r_state;
      w_cnt = r_cnt;
      unique case (r_state)
         S_IDLE: begin
            if (bus.reset_req) begin
               w_nxt = S_ISO;
               w_cnt = '0;
            end
         end
         S_ISO: begin
            if (bus.isolate_done) begin
               w_nxt = S_RST;
               w_cnt = RLoad;
            end else if (r_cnt != TMax) begin
               w_cnt = r_cnt + One;
            end
         end
         S_RST: begin
            if (r_cnt == '0) begin
               w_nxt = S_REL;
               w_cnt = '0;
            end else begin
               w_cnt = r_cnt - One;
            end
         end
         S_REL: begin
            if (!bus.isolate_done) begin
               w_nxt = S_DONE;
               w_cnt = '0;
            end else if (r_cnt != TMax) begin
               w_cnt = r_cnt + One;
            end
         end
         default: begin
            w_nxt = S_IDLE;
            w_cnt = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_fired <= 1'b0;
         r_ireq  <= 1'b0;
         r_drst  <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_nxt;
         r_cnt   <= w_cnt;
         r_fired <= (w_nxt != r_state) ? 1'b0 : (r_fired | w_hit);
         r_ireq  <= (w_nxt == S_ISO) || (w_nxt == S_RST);
         r_drst  <= (w_nxt == S_RST);
         r_busy  <= (w_nxt != S_IDLE);
         r_done  <= (w_nxt == S_DONE);
         r_err   <= w_hit | (r_err & ~bus.timeout_clear);
      end
   end

   assign bus.isolate_req    = r_ireq;
   assign bus.downstream_rst = r_drst;
   assign bus.reset_busy     = r_busy;
   assign bus.reset_done     = r_done;
   assign bus.timeout_err    = r_err;
endmodule

// File: tb/tb_br_amba_axi_isolate_rst_seq.sv
// Randomized bench: sequence timelines predicted from handshake delays.
module tb_br_amba_axi_isolate_rst_seq;
   localparam int RC = 4;
   localparam int TC = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad = 0;
   logic m_err = 1'b0;

   always #5 clk = ~clk;

   br_amba_axi_isolate_rst_seq_if bus ();

   br_amba_axi_isolate_rst_seq #(
      .ResetCycles(RC),
      .TimeoutCycles(TC)
   ) u_dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );

   task automatic chk(input string tag, input int obs, input int exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s t=%0t got=%0d want=%0d", tag, $time, obs, exp);
      end
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_req"}, int'(bus.isolate_req), 0);
      chk({tag, "_rst"}, int'(bus.downstream_rst), 0);
      chk({tag, "_busy"}, int'(bus.reset_busy), 0);
      chk({tag, "_done"}, int'(bus.reset_done), 0);
   endtask

   // d1/d2: cycles from phase entry until isolate_done rises/falls.
   task automatic run_seq(input int d1, input int d2, input int gap,
                          input int abort_at);
      int dr, rl, fl;
      logic clr, set, p_req, p_done;
      dr = 1 + d1;
      rl = dr + RC + 1;
      fl = rl + d2;
      p_req = 1'b0;
      p_done = 1'b0;
      for (int c = 0; c <= fl + 1; c++) begin
         @(posedge clk);
         #1;
         bus.reset_req = (c == 0) ? 1'b1 : 1'($urandom_range(0, 1));
         bus.isolate_done = (c >= dr) && (c < fl);
         clr = ($urandom_range(0, 4) == 0);
         bus.timeout_clear = clr;
         if (c == abort_at) begin
            #2;
            rst_n = 1'b0;
            #1;
            chk_idle("abort");
            chk("abort_err", int'(bus.timeout_err), 0);
            m_err = 1'b0;
            for (int k = 0; k < 2; k++) begin
               @(negedge clk);
               chk_idle("inrst");
            end
            @(posedge clk);
            #1;
            bus.reset_req = 1'b0;
            bus.isolate_done = 1'b0;
            bus.timeout_clear = 1'b0;
            rst_n = 1'b1;
            for (int k = 0; k < 4; k++) begin
               @(negedge clk);
               chk_idle("post");
            end
            return;
         end
         @(negedge clk);
         chk("req", int'(bus.isolate_req), int'(c >= 1 && c <= dr + RC));
         chk("drst", int'(bus.downstream_rst),
             int'(c >= dr + 1 && c <= dr + RC));
         chk("busy", int'(bus.reset_busy), int'(c >= 1 && c <= fl + 1));
         chk("done", int'(bus.reset_done), int'(c == fl + 1));
         chk("err", int'(bus.timeout_err), int'(m_err));
         if (bus.downstream_rst)
            chk("rst_impl", int'(bus.isolate_req && bus.isolate_done), 1);
         if (c >= 1 && bus.isolate_req !== p_req)
            chk("4phase", int'(p_done), int'(p_req));
         p_req = bus.isolate_req;
         p_done = bus.isolate_done;
         set = (c == 1 + TC && 1 + TC <= dr) ||
               (c == rl + TC && rl + TC <= fl);
         m_err = set | (m_err & ~clr);
      end
      for (int g = 0; g < gap; g++) begin
         @(posedge clk);
         #1;
         bus.reset_req = 1'b0;
         bus.isolate_done = 1'b0;
         clr = ($urandom_range(0, 2) == 0);
         bus.timeout_clear = clr;
         @(negedge clk);
         chk_idle("gap");
         chk("gap_err", int'(bus.timeout_err), int'(m_err));
         m_err = m_err & ~clr;
      end
   endtask

   initial begin
      bus.reset_req = 1'b0;
      bus.isolate_done = 1'b0;
      bus.timeout_clear = 1'b0;
      #3;
      chk_idle("reset");
      chk("reset_err", int'(bus.timeout_err), 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      run_seq(2, 2, 1, -1);
      run_seq(0, 0, 0, -1);
      run_seq(12, 0, 2, -1);
      run_seq(1, 12, 0, -1);
      run_seq(2, 2, 0, 5);
      run_seq(3, 1, 1, -1);
      for (int i = 0; i < 30; i++)
         run_seq(int'($urandom_range(0, 12)), int'($urandom_range(0, 12)),
                 int'($urandom_range(0, 3)), -1);
      run_seq(4, 4, 0, 2);
      run_seq(0, 11, 0, -1);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/br_amba_axi_isolate_rst_seq.md
BR_AMBA_AXI_ISOLATE_RST_SEQ -- requirements
Module: br_amba_axi_isolate_rst_seq

Interface
REQ-001 Parameter ResetCycles SHALL default to 16: number of cycles downstream_rst is held high; legal range >= 1, checked by elaboration assertion.
REQ-002 Parameter TimeoutCycles SHALL default to 1024: handshake wait limit in cycles; 0 disables timeout detection; legal range >= 0.
REQ-003 Port clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port rst_n  input  1  SHALL be the reset: asynchronous assertion, active-low.
REQ-005 Port reset_req  input  1  SHALL request a downstream reset sequence; sampled only in IDLE.
REQ-006 Port reset_busy  output  1  SHALL be high whenever the FSM is not in IDLE.
REQ-007 Port reset_done  output  1  SHALL be a single-cycle pulse marking sequence completion.
REQ-008 Port isolate_req  output  1  SHALL be the 4-phase request to the AXI isolate stage.
REQ-009 Port isolate_done  input  1  SHALL be the 4-phase acknowledge from the AXI isolate stage.
REQ-010 Port downstream_rst  output  1  SHALL be the active-high reset driven to the downstream AXI subordinate.
REQ-011 Port timeout_err  output  1  SHALL be a sticky flag: handshake wait exceeded TimeoutCycles.
REQ-012 Port timeout_clear  input  1  SHALL clear timeout_err.

Function
REQ-013 All outputs SHALL be driven directly from flops; no combinational input-to-output path.
REQ-014 FSM states SHALL be IDLE, ISOLATE, RESET, RELEASE, DONE.
REQ-015 IDLE -> ISOLATE SHALL occur when reset_req=1 is sampled; isolate_req=1 from the next cycle.
REQ-016 ISOLATE SHALL hold isolate_req=1; isolate_done=1 sampled at cycle t -> RESET with downstream_rst=1 from t+1.
REQ-017 RESET SHALL hold downstream_rst=1 and isolate_req=1 for exactly ResetCycles cycles, counted by a down-counter loaded on entry.
REQ-018 RESET -> RELEASE SHALL drop downstream_rst and isolate_req in the same cycle.
REQ-019 RELEASE SHALL hold isolate_req=0; isolate_done=0 sampled at cycle t -> DONE at t+1.
REQ-020 DONE SHALL last one cycle with reset_done=1, then return to IDLE; reset_busy is high during DONE.
REQ-021 isolate_req SHALL never change while the previous 4-phase phase is unacknowledged (no drop before isolate_done=1, no rise before isolate_done=0).
REQ-022 reset_req asserted outside IDLE SHALL be ignored and not queued; reset_req held high through DONE starts a new sequence on the IDLE cycle that follows.
REQ-023 The wait counter SHALL be cleared on entry to ISOLATE and RELEASE and increment each cycle in those states, saturating at TimeoutCycles.
REQ-024 When the wait counter reaches TimeoutCycles (TimeoutCycles>0), timeout_err SHALL be set on the next cycle; the FSM keeps waiting (no abort).
REQ-025 timeout_clear SHALL clear timeout_err on the next cycle; simultaneous set and clear SHALL leave timeout_err set.
REQ-026 A shared counter SHALL be sized clog2(max(ResetCycles, TimeoutCycles)+1) bits with no wrap-around.
REQ-027 With isolate_done already high on ISOLATE entry, RESET SHALL be entered after exactly one ISOLATE cycle.

Reset
REQ-028 rst_n=0 SHALL immediately force: state IDLE, isolate_req=0, downstream_rst=0, reset_busy=0, reset_done=0, timeout_err=0, counter=0.
REQ-029 rst_n assertion mid-sequence SHALL abort the sequence with no reset_done pulse; after release, the block waits in IDLE for a new reset_req.

Verification
REQ-030 ResetCycles=4: reset_req pulse at cycle 0, isolate_done rises at 3 -> isolate_req=1 cycles 1-7, downstream_rst=1 cycles 4-7, both 0 at 8.
REQ-031 Continuing REQ-030, isolate_done falls at cycle 10 -> reset_done=1 only in cycle 11, reset_busy=0 from 12.
REQ-032 TimeoutCycles=8, isolate_done held 0 -> timeout_err=1 at ISOLATE entry+9, isolate_req stays 1; timeout_clear pulse -> timeout_err=0 next cycle.
REQ-033 reset_req pulsed during RESET -> ignored; exactly one reset_done pulse, FSM returns to IDLE.
REQ-034 rst_n driven low during RESET -> downstream_rst and isolate_req low immediately; no reset_done; new reset_req after release runs a full sequence.
REQ-035 Bound the block to the 4-phase master checker on isolate_req/isolate_done; assert downstream_rst implies isolate_req && isolate_done.
